// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute sequencer for the 16-bit
// datapath. Fetches from a synchronous ROM (1-cycle read latency), decodes
// the opcode in IR[15:12] and drives the RAM, register-file and ALU controls.
// All control outputs are registered and are computed from the next state,
// so each one is valid for exactly the duration of its state.
module control_unit #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned D_ADDR_W = 8,
  parameter int unsigned R_ADDR_W = 4,
  parameter int unsigned I_ADDR_W = 7,
  parameter logic [3:0]  ALU_PASS = 4'd0,
  parameter logic [3:0]  ALU_ADD  = 4'd1,
  parameter logic [3:0]  ALU_SUB  = 4'd2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    I_data,
  output logic [I_ADDR_W-1:0] I_addr,
  output logic [D_ADDR_W-1:0] D_addr,
  output logic                D_wr,
  output logic [R_ADDR_W-1:0] RF_W_addr,
  output logic [R_ADDR_W-1:0] RF_A_addr,
  output logic [R_ADDR_W-1:0] RF_B_addr,
  output logic                RF_W_en,
  output logic                RF_s,
  output logic [3:0]          ALU_sel,
  output logic [I_ADDR_W-1:0] PC,
  output logic [WIDTH-1:0]    IR,
  output logic                halted
);

  typedef enum logic [3:0] {
    S_INIT       = 4'd0,
    S_FETCH      = 4'd1,
    S_FETCH_WAIT = 4'd2,
    S_DECODE     = 4'd3,
    S_STORE      = 4'd4,
    S_LOAD_A     = 4'd5,
    S_LOAD_B     = 4'd6,
    S_ADD        = 4'd7,
    S_SUB        = 4'd8,
    S_HALT       = 4'd9
  } state_t;

  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;

  localparam logic [I_ADDR_W-1:0] PC_ONE = {{(I_ADDR_W-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [I_ADDR_W-1:0]   pc_q, pc_d;
  logic [WIDTH-1:0]      ir_q, ir_d;

  logic                  d_wr_q, d_wr_d;
  logic                  rf_w_en_q, rf_w_en_d;
  logic                  rf_s_q, rf_s_d;
  logic [3:0]            alu_sel_q, alu_sel_d;
  logic [R_ADDR_W-1:0]   rf_a_addr_q, rf_a_addr_d;
  logic                  halted_q, halted_d;

  // Next-state, PC and IR sequencing; IR/PC only move at the end of FETCH_WAIT.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_INIT:       state_d = S_FETCH;
      S_FETCH:      state_d = S_FETCH_WAIT;
      S_FETCH_WAIT: begin
        state_d = S_DECODE;
        ir_d    = I_data;
        pc_d    = pc_q + PC_ONE;
      end
      S_DECODE: begin
        case (ir_q[15:12])
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOAD_A;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_FETCH;
        endcase
      end
      S_LOAD_A:     state_d = S_LOAD_B;
      S_LOAD_B:     state_d = S_FETCH;
      S_STORE:      state_d = S_FETCH;
      S_ADD:        state_d = S_FETCH;
      S_SUB:        state_d = S_FETCH;
      S_HALT:       state_d = S_HALT;
      default:      state_d = S_INIT;
    endcase
  end

  // Moore output decode from the upcoming state so the outputs can be registered.
  always_comb begin
    d_wr_d      = 1'b0;
    rf_w_en_d   = 1'b0;
    rf_s_d      = 1'b1;
    alu_sel_d   = ALU_PASS;
    halted_d    = 1'b0;
    rf_a_addr_d = ir_d[7:4];
    case (state_d)
      S_STORE: begin
        d_wr_d      = 1'b1;
        rf_a_addr_d = ir_d[11:8];
      end
      S_LOAD_B: begin
        rf_s_d    = 1'b0;
        rf_w_en_d = 1'b1;
      end
      S_ADD: begin
        rf_w_en_d = 1'b1;
        alu_sel_d = ALU_ADD;
      end
      S_SUB: begin
        rf_w_en_d = 1'b1;
        alu_sel_d = ALU_SUB;
      end
      S_HALT:  halted_d = 1'b1;
      default: halted_d = 1'b0;
    endcase
  end

  // State, architectural registers and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      pc_q        <= '0;
      ir_q        <= '0;
      d_wr_q      <= 1'b0;
      rf_w_en_q   <= 1'b0;
      rf_s_q      <= 1'b1;
      alu_sel_q   <= ALU_PASS;
      rf_a_addr_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      d_wr_q      <= d_wr_d;
      rf_w_en_q   <= rf_w_en_d;
      rf_s_q      <= rf_s_d;
      alu_sel_q   <= alu_sel_d;
      rf_a_addr_q <= rf_a_addr_d;
      halted_q    <= halted_d;
    end
  end

  assign I_addr    = pc_q;
  assign PC        = pc_q;
  assign IR        = ir_q;
  assign D_addr    = ir_q[7:0];
  assign RF_W_addr = ir_q[11:8];
  assign RF_B_addr = ir_q[3:0];
  assign RF_A_addr = rf_a_addr_q;
  assign D_wr      = d_wr_q;
  assign RF_W_en   = rf_w_en_q;
  assign RF_s      = rf_s_q;
  assign ALU_sel   = alu_sel_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench. A cycle-count model derived from the
// instruction rules predicts PC/IR/halted per cycle and every write event;
// a negedge monitor compares the DUT against those predictions.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] I_data;
  logic [6:0]  I_addr;
  logic [7:0]  D_addr;
  logic        D_wr;
  logic [3:0]  RF_W_addr, RF_A_addr, RF_B_addr;
  logic        RF_W_en, RF_s;
  logic [3:0]  ALU_sel;
  logic [6:0]  PC;
  logic [15:0] IR;
  logic        halted;

  control_unit dut (
    .clk(clk), .rst(rst), .I_data(I_data), .I_addr(I_addr), .D_addr(D_addr),
    .D_wr(D_wr), .RF_W_addr(RF_W_addr), .RF_A_addr(RF_A_addr),
    .RF_B_addr(RF_B_addr), .RF_W_en(RF_W_en), .RF_s(RF_s), .ALU_sel(ALU_sel),
    .PC(PC), .IR(IR), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous instruction ROM with one cycle of read latency.
  logic [15:0] rom [128];
  always @(posedge clk) I_data <= rom[I_addr];

  typedef struct {
    int          cyc;
    logic [33:0] sig;
  } ev_t;

  ev_t         exp_q[$];
  logic [6:0]  exp_pc   [1024];
  logic [15:0] exp_ir   [1024];
  logic        exp_halt [1024];
  int          ncyc    = 0;
  time         t_rel   = 0;
  logic        mon_en  = 1'b0;
  int          end_req = 0;
  int          end_done = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Predicts the whole run from cycle counts: NOOP 3, STORE/ADD/SUB 4, LOAD 5.
  task automatic build_model(input int n);
    int f, len, ecyc;
    logic [6:0]  pc;
    logic [15:0] ir, cur_ir;
    logic [3:0]  op, alu, a_addr;
    logic        stop;
    ev_t         e;
    exp_q.delete();
    ncyc = n;
    for (int c = 0; c < n; c++) begin
      exp_pc[c] = 7'd0; exp_ir[c] = 16'd0; exp_halt[c] = 1'b0;
    end
    pc = 7'd0; cur_ir = 16'd0; f = 1; stop = 1'b0;
    while (f < n && !stop) begin
      ir = rom[pc];
      op = ir[15:12];
      for (int c = f; c < f + 2 && c < n; c++) begin
        exp_pc[c] = pc; exp_ir[c] = cur_ir;
      end
      cur_ir = ir;
      if (op == 4'd5) begin
        for (int c = f + 2; c < n; c++) begin
          exp_pc[c] = pc + 7'd1; exp_ir[c] = ir; exp_halt[c] = (c >= f + 3);
        end
        stop = 1'b1;
      end else begin
        if (op == 4'd1 || op == 4'd3 || op == 4'd4) len = 4;
        else if (op == 4'd2) len = 5;
        else len = 3;
        for (int c = f + 2; c < f + len && c < n; c++) begin
          exp_pc[c] = pc + 7'd1; exp_ir[c] = ir;
        end
        if (len > 3) begin
          ecyc   = f + len - 1;
          alu    = (op == 4'd3) ? 4'd1 : ((op == 4'd4) ? 4'd2 : 4'd0);
          a_addr = (op == 4'd1) ? ir[11:8] : ir[7:4];
          e.cyc  = ecyc;
          e.sig  = {op == 4'd1, op != 4'd1, op != 4'd2, alu, ir[7:0], ir[11:8],
                    a_addr, ir[3:0], pc + 7'd1};
          if (ecyc < n) exp_q.push_back(e);
        end
        pc = pc + 7'd1;
        f  = f + len;
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
    end
  endtask

  // Monitor: reset values while rst is high, otherwise per-cycle scoreboard.
  always @(negedge clk) begin
    int c;
    ev_t e;
    if (rst) begin
      check("reset_values",
            {I_addr, D_addr, D_wr, RF_W_addr, RF_A_addr, RF_B_addr, RF_W_en, RF_s, ALU_sel, PC, IR, halted},
            {7'd0, 8'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd0, 7'd0, 16'd0, 1'b0});
    end else if (mon_en) begin
      c = int'(($time - t_rel - 3) / 10);
      if (c < ncyc) begin
        check("pc_iaddr_ir", {I_addr, PC, IR}, {exp_pc[c], exp_pc[c], exp_ir[c]});
        check("halted", {63'd0, halted}, {63'd0, exp_halt[c]});
        if (D_wr || RF_W_en) begin
          if (exp_q.size() > 0 && exp_q[0].cyc == c) begin
            e = exp_q.pop_front();
            check("write_event",
                  {D_wr, RF_W_en, RF_s, ALU_sel, D_addr, RF_W_addr, RF_A_addr, RF_B_addr, PC},
                  e.sig);
          end else begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_write: got D_wr=%0b RF_W_en=%0b IR=%0h expected none at cycle %0d",
                     D_wr, RF_W_en, IR, c);
          end
        end else begin
          if (exp_q.size() > 0 && exp_q[0].cyc == c) begin
            e = exp_q.pop_front();
            n_tests++; n_fail++;
            $display("FAIL missing_write: got none expected %0h at cycle %0d", e.sig, c);
          end
          check("idle_ctl", {59'd0, RF_s, ALU_sel}, {59'd0, 1'b1, 4'd0});
        end
      end
      if (end_req != end_done) begin
        end_done = end_req;
        check("all_events_seen", 64'(exp_q.size()), 64'd0);
      end
    end
  end

  // Reset for 3 cycles, release, then let the program run for n cycles.
  task automatic run_prog(input int n);
    rst = 1'b1; mon_en = 1'b0;
    build_model(n);
    repeat (3) @(posedge clk);
    #2; rst = 1'b0; t_rel = $time; mon_en = 1'b1;
    repeat (n) @(posedge clk);
    #2; end_req++;
    @(negedge clk); #1; mon_en = 1'b0; rst = 1'b1;
  endtask

  task automatic clear_rom(input logic [15:0] v);
    for (int i = 0; i < 128; i++) rom[i] = v;
  endtask

  initial begin
    int sel;
    logic [15:0] w;
    #1 rst = 1'b1;
    clear_rom(16'h0000);
    run_prog(30);

    clear_rom(16'h0000); rom[0] = 16'h2305;
    run_prog(20);

    clear_rom(16'h0000); rom[0] = 16'h3412; rom[1] = 16'h4512;
    run_prog(20);

    clear_rom(16'h0000); rom[0] = 16'h1A07; rom[1] = 16'h5000;
    run_prog(40);

    clear_rom(16'hF000);
    run_prog(128 * 3 + 12);

    // Asynchronous reset while the LOAD is in LOAD_A (cycle 4 after release).
    clear_rom(16'h0000); rom[0] = 16'h2305;
    rst = 1'b1; mon_en = 1'b0;
    build_model(5);
    repeat (3) @(posedge clk);
    #2; rst = 1'b0; t_rel = $time; mon_en = 1'b1;
    repeat (4) @(posedge clk);
    #2; rst = 1'b1; mon_en = 1'b0;
    repeat (3) @(posedge clk);
    run_prog(20);

    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 128; i++) begin
        w   = 16'($urandom);
        sel = $urandom_range(0, 15);
        if (sel <= 4) w[15:12] = 4'(sel);
        else if (sel == 5 && s == 2) w[15:12] = 4'd5;
        else if (sel <= 11) w[15:12] = 4'($urandom_range(1, 4));
        else w[15:12] = 4'($urandom_range(6, 15));
        rom[i] = w;
      end
      run_prog(300);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
